// File: rtl/fw_uart_loader.sv
// Framed UART firmware loader: packs little-endian bytes into 32-bit words, writes them to core SRAM,
// checks the trailing checksum, then releases the core. Macro FW_LOADER_READBACK_EN adds per-word readback.
module fw_uart_loader #(
    parameter int DEPTH          = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        RST,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic        nFW_mode,
    output logic        core_nRST,
    output logic [31:0] fw_mem_addr,
    output logic [31:0] fw_data_in,
    output logic [3:0]  fw_byte_en,
    output logic        fw_wr_en,
    output logic        fw_rd_en,
    input  logic [31:0] fw_data_out,
    output logic        busy,
    output logic        done,
    output logic [2:0]  error
);

    typedef enum logic [3:0] {
        ST_IDLE, ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_WRITE,
        ST_VERIFY_RD, ST_VERIFY_CMP, ST_CSUM, ST_DONE, ST_ERR
    } state_t;

    localparam logic [7:0]  LP_SYNC     = 8'h53;
    localparam logic [16:0] LP_DEPTH    = 17'(DEPTH);
    localparam logic [31:0] LP_TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

    state_t      r_state, w_state_next, w_norm_next;
    logic [2:0]  w_err_code, w_norm_err;
    logic        w_start, w_active, w_active_next, w_in_strobe, w_tmo_hit, w_word_end;
    logic [15:0] r_len, r_addr, w_len_full, w_addr_inc;
    logic [1:0]  r_byte_cnt;
    logic [31:0] r_word, w_word_next, r_tmo;
    logic [7:0]  r_sum;

    logic        r_nfw_mode, r_core_nrst, r_fw_wr_en, r_busy, r_done;
    logic [31:0] r_fw_mem_addr, r_fw_data_in;
    logic [3:0]  r_fw_byte_en;
    logic [2:0]  r_error;

    assign w_active      = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_ERR);
    assign w_active_next = (w_state_next != ST_IDLE) && (w_state_next != ST_DONE) && (w_state_next != ST_ERR);
    assign w_in_strobe   = (r_state == ST_WRITE) || (r_state == ST_VERIFY_RD) || (r_state == ST_VERIFY_CMP);
    assign w_tmo_hit     = w_active && !rx_valid && (r_tmo >= LP_TMO_LAST);
    assign w_len_full    = {rx_data, r_len[7:0]};
    assign w_addr_inc    = r_addr + 16'd1;
`ifdef FW_LOADER_READBACK_EN
    assign w_word_end    = (r_state == ST_VERIFY_CMP);
`else
    assign w_word_end    = (r_state == ST_WRITE);
`endif

    // Word register with the incoming byte merged into its lane
    always_comb begin
        w_word_next = r_word;
        case (r_byte_cnt)
            2'd0:    w_word_next[7:0]   = rx_data;
            2'd1:    w_word_next[15:8]  = rx_data;
            2'd2:    w_word_next[23:16] = rx_data;
            2'd3:    w_word_next[31:24] = rx_data;
            default: w_word_next = r_word;
        endcase
    end

    // Frame parsing next state, before overrun/timeout overrides
    always_comb begin
        w_norm_next = r_state;
        w_norm_err  = 3'd0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE, ST_ERR: begin
                if (rx_valid && (rx_data == LP_SYNC)) begin
                    w_norm_next = ST_LEN_LO;
                    w_start     = 1'b1;
                end else begin
                    w_norm_next = r_state;
                end
            end
            ST_LEN_LO: begin
                if (rx_valid) begin
                    w_norm_next = ST_LEN_HI;
                end else begin
                    w_norm_next = r_state;
                end
            end
            ST_LEN_HI: begin
                if (!rx_valid) begin
                    w_norm_next = r_state;
                end else if ({1'b0, w_len_full} > LP_DEPTH) begin
                    w_norm_next = ST_ERR;
                    w_norm_err  = 3'd1;
                end else if (w_len_full == 16'd0) begin
                    w_norm_next = ST_CSUM;
                end else begin
                    w_norm_next = ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_valid && (r_byte_cnt == 2'd3)) begin
                    w_norm_next = ST_WRITE;
                end else begin
                    w_norm_next = r_state;
                end
            end
`ifdef FW_LOADER_READBACK_EN
            ST_WRITE:     w_norm_next = ST_VERIFY_RD;
            ST_VERIFY_RD: w_norm_next = ST_VERIFY_CMP;
            ST_VERIFY_CMP: begin
                if (fw_data_out != r_word) begin
                    w_norm_next = ST_ERR;
                    w_norm_err  = 3'd5;
                end else if (w_addr_inc < r_len) begin
                    w_norm_next = ST_DATA;
                end else begin
                    w_norm_next = ST_CSUM;
                end
            end
`else
            ST_WRITE: begin
                if (w_addr_inc < r_len) begin
                    w_norm_next = ST_DATA;
                end else begin
                    w_norm_next = ST_CSUM;
                end
            end
`endif
            ST_CSUM: begin
                if (!rx_valid) begin
                    w_norm_next = r_state;
                end else if (rx_data == r_sum) begin
                    w_norm_next = ST_DONE;
                end else begin
                    w_norm_next = ST_ERR;
                    w_norm_err  = 3'd2;
                end
            end
            ST_DONE: w_norm_next = ST_DONE;
            default: w_norm_next = ST_IDLE;
        endcase
    end

    // A byte landing while the SRAM port is busy is lost, so it outranks everything else
    always_comb begin
        w_state_next = w_norm_next;
        w_err_code   = w_norm_err;
        if (w_in_strobe && rx_valid) begin
            w_state_next = ST_ERR;
            w_err_code   = 3'd4;
        end else if (w_tmo_hit) begin
            w_state_next = ST_ERR;
            w_err_code   = 3'd3;
        end else begin
            w_state_next = w_norm_next;
            w_err_code   = w_norm_err;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Datapath: length, byte lane, word, address, checksum and idle timer
    always_ff @(posedge clk) begin
        if (RST) begin
            r_len      <= 16'd0;
            r_addr     <= 16'd0;
            r_byte_cnt <= 2'd0;
            r_word     <= 32'd0;
            r_sum      <= 8'd0;
            r_tmo      <= 32'd0;
        end else begin
            if (w_start) begin
                r_byte_cnt <= 2'd0;
                r_addr     <= 16'd0;
                r_sum      <= 8'd0;
            end else if ((r_state == ST_DATA) && rx_valid) begin
                r_byte_cnt <= r_byte_cnt + 2'd1;
                r_sum      <= r_sum + rx_data;
                r_word     <= w_word_next;
            end else if (w_word_end && (w_state_next != ST_ERR)) begin
                r_addr     <= w_addr_inc;
            end
            if ((r_state == ST_LEN_LO) && rx_valid) begin
                r_len[7:0] <= rx_data;
            end
            if ((r_state == ST_LEN_HI) && rx_valid) begin
                r_len[15:8] <= rx_data;
            end
            r_tmo <= (rx_valid || !w_active) ? 32'd0 : r_tmo + 32'd1;
        end
    end

    // Registered outputs derived from the upcoming state
    always_ff @(posedge clk) begin
        if (RST) begin
            r_fw_wr_en    <= 1'b0;
            r_fw_byte_en  <= 4'h0;
            r_fw_data_in  <= 32'd0;
            r_fw_mem_addr <= 32'd0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_nfw_mode    <= 1'b0;
            r_core_nrst   <= 1'b0;
            r_error       <= 3'd0;
        end else begin
            r_fw_wr_en    <= (w_state_next == ST_WRITE);
            r_fw_byte_en  <= (w_state_next == ST_WRITE) ? 4'hF : 4'h0;
            r_fw_data_in  <= (w_state_next == ST_WRITE) ? w_word_next : 32'd0;
            r_fw_mem_addr <= ((w_state_next == ST_WRITE) || (w_state_next == ST_VERIFY_RD)) ?
                             {16'd0, r_addr} : 32'd0;
            r_busy        <= w_active_next;
            r_done        <= (w_state_next == ST_DONE);
            r_nfw_mode    <= (w_state_next == ST_DONE);
            r_core_nrst   <= (w_state_next == ST_DONE);
            if (w_start) begin
                r_error <= 3'd0;
            end else if ((w_state_next == ST_ERR) && (r_state != ST_ERR)) begin
                r_error <= w_err_code;
            end
        end
    end

`ifdef FW_LOADER_READBACK_EN
    logic r_fw_rd_en;

    // Readback strobe
    always_ff @(posedge clk) begin
        if (RST) begin
            r_fw_rd_en <= 1'b0;
        end else begin
            r_fw_rd_en <= (w_state_next == ST_VERIFY_RD);
        end
    end
    assign fw_rd_en = r_fw_rd_en;
`else
    logic w_unused_rd;
    assign w_unused_rd = ^fw_data_out;
    assign fw_rd_en    = 1'b0;
`endif

    assign fw_wr_en    = r_fw_wr_en;
    assign fw_byte_en  = r_fw_byte_en;
    assign fw_data_in  = r_fw_data_in;
    assign fw_mem_addr = r_fw_mem_addr;
    assign busy        = r_busy;
    assign done        = r_done;
    assign nFW_mode    = r_nfw_mode;
    assign core_nRST   = r_core_nrst;
    assign error       = r_error;

endmodule

// File: doc/fw_uart_loader.md
# fw_uart_loader

Firmware loader that sits directly upstream of a core unit's FW upload interface. It parses a framed byte stream from the UART receiver, packs bytes into 32-bit little-endian words, writes them into the core's private SRAM via the FW port, checks a trailing checksum, and then hands the SRAM back to the core by raising `nFW_mode` and releasing the core reset.

## Interface
Parameters:
- `DEPTH`, 1024: SRAM capacity in 32-bit words; the maximum legal word count.
- `TIMEOUT_CYCLES`, 1000000: maximum idle clk cycles allowed between bytes once a frame has started.

Ports:
- `clk` in 1: system clock.
- `RST` in 1: synchronous, active-high reset.
- `rx_valid` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte.
- `nFW_mode` out 1: 0 = loader owns SRAM; 1 = core owns SRAM.
- `core_nRST` out 1: active-low reset to the core unit.
- `fw_mem_addr` out 32: word index, zero-extended.
- `fw_data_in` out 32: write data.
- `fw_byte_en` out 4: byte enables.
- `fw_wr_en` out 1: write strobe.
- `fw_rd_en` out 1: read strobe (readback only).
- `fw_data_out` in 32: SRAM read data, valid 1 cycle after `fw_rd_en`.
- `busy` out 1: frame in progress.
- `done` out 1: load succeeded; sticky.
- `error` out 3: 0 none, 1 length, 2 checksum, 3 timeout, 4 overrun, 5 verify mismatch; sticky until next frame or reset.

## Operation
- Frame format: `0x53` ('S'), LEN_LO, LEN_HI (16-bit word count N), 4·N data bytes (LSB first per word), CSUM. CSUM is the 8-bit modulo-256 sum of all data bytes.
- States:
  - IDLE: wait for 'S'; all other bytes are ignored. On 'S': `busy`=1, clear `error`/`done`, byte counter=0, address=0, sum=0.
  - LEN_LO, LEN_HI: latch N. N>DEPTH → ERR(1). N==0 → CSUM. Otherwise → DATA.
  - DATA: shift each byte into the word register at lane `byte_cnt[1:0]` and add it to sum. After the 4th byte → WRITE.
  - WRITE: exactly one cycle. `fw_wr_en`=1, `fw_byte_en`=4'hF, `fw_mem_addr`=word address, `fw_data_in`=packed word. Then the address increments.
  - After WRITE: → VERIFY if the macro is enabled; else → DATA if address<N, else → CSUM.
  - CSUM: received byte == sum → DONE; otherwise → ERR(2).
  - DONE: `nFW_mode`=1, `core_nRST`=1, `done`=1, `busy`=0. Held until RST; further bytes are ignored.
  - ERR: `busy`=0, `nFW_mode`=0, `core_nRST`=0. An 'S' restarts the frame as in IDLE.
- Timeout: a counter clears on every `rx_valid` and runs in LEN_LO through CSUM. Reaching TIMEOUT_CYCLES → ERR(3).
- `rx_valid` during WRITE/VERIFY states → ERR(4). The byte is dropped.
- Address arithmetic is 16-bit internally, zero-extended onto `fw_mem_addr`. Address wrap cannot occur because N≤DEPTH.

## Timing
- Reset values: `nFW_mode`=0, `core_nRST`=0, `fw_wr_en`=0, `fw_rd_en`=0, `fw_byte_en`=0, `fw_mem_addr`=0, `fw_data_in`=0, `busy`=0, `done`=0, `error`=0. State → IDLE.
- All outputs are registered.
- `fw_wr_en` asserts the cycle after the clock edge that samples the 4th byte of a word.
- `done` and `nFW_mode` rise the cycle after the CSUM byte is sampled.
- `core_nRST` rises together with `nFW_mode`.
- RST mid-frame aborts immediately. SRAM contents are undefined; the core stays in reset.
- `fw_byte_en`/`fw_data_in` return to 0 whenever no strobe is asserted.

## Configuration
- `FW_LOADER_READBACK_EN` defined: after each WRITE, add states VERIFY_RD and VERIFY_CMP.
  - VERIFY_RD: `fw_rd_en`=1 at the same address for 1 cycle.
  - VERIFY_CMP: compare `fw_data_out` with the written word. Mismatch → ERR(5). Each word then costs 3 cycles.
- Undefined: no readback; `fw_rd_en` is tied to 0 and error code 5 is never produced.

## Test plan
- Frame 'S',01,00,78,56,34,12,14 → one write, addr 0, data 0x12345678, `byte_en` F; `done`=1, `nFW_mode`=1, `core_nRST`=1.
- N=1024 with byte value (i mod 256) and correct CSUM → 1024 writes at addresses 0..1023, `done`=1. Same frame with CSUM+1 → `error`=2, `nFW_mode`=0.
- Frame 'S',01,04 (N=1025) → `error`=1 after LEN_HI, no writes.
- 'S',02,00 then 3 data bytes then silence for TIMEOUT_CYCLES → `error`=3 with no write issued. A following 'S' frame loads correctly.
- Garbage bytes 00,FF before 'S' are ignored. RST pulse after 2 data words → all outputs at reset values; a new frame succeeds.
- With FW_LOADER_READBACK_EN defined, the SRAM model corrupts bit 0 of word 3 → `error`=5 after the 4th write.
